// File: rtl/tt_patseq_pkg.sv
// Shared opcodes, states and field positions for the TT pattern sequencer.
// Status pins are enabled by defining TT_PATSEQ_STATUS_EN.
package tt_patseq_pkg;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_WRITE     = 3'd1;
  localparam logic [2:0] OP_SET_LEN   = 3'd2;
  localparam logic [2:0] OP_SET_DIV   = 3'd3;
  localparam logic [2:0] OP_PLAY_ONCE = 3'd4;
  localparam logic [2:0] OP_PLAY_LOOP = 3'd5;
  localparam logic [2:0] OP_STOP      = 3'd6;
  localparam logic [2:0] OP_CLR       = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam int ST_BUSY = 7;
  localparam int ST_LOOP = 6;
  localparam int ST_DONE = 5;
  localparam int ST_ERR  = 4;

  localparam int STB_BIT = 7;
  localparam int OP_HI   = 6;
  localparam int OP_LO   = 4;
  localparam int ARG_HI  = 3;
  localparam int ARG_LO  = 0;

endpackage

// File: rtl/tt_patseq_mem.sv
// Pattern store: DEPTH x 8 register file, sync write, async read.
// Contents are deliberately left unreset.
module tt_patseq_mem
  import tt_patseq_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/tt_pattern_seq.sv
// Tiny Tapeout pattern sequencer: load bytes, play them on uo_out.
// Define TT_PATSEQ_STATUS_EN to drive status on uio_out[7:4].
module tt_pattern_seq
  import tt_patseq_pkg::*;
#(
  parameter int         DEPTH      = 16,
  parameter logic [7:0] IDLE_VALUE = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic          strb_q;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW:0]   len_q, len_d;
  logic [3:0]    div_q, div_d;
  logic [3:0]    tick_q, tick_d;
  logic          loop_q, loop_d;
  logic          err_q, err_d;
  logic [7:0]    uo_q, uo_d;
  logic          fire, we, last, run;
  logic [2:0]    op;
  logic [3:0]    arg;
  logic [4:0]    arg_len;
  logic [7:0]    rdata;
  logic          unused_uio;

  assign op         = ui_in[OP_HI:OP_LO];
  assign arg        = ui_in[ARG_HI:ARG_LO];
  assign fire       = ui_in[STB_BIT] & ~strb_q & ena;
  assign run        = (state_q == S_RUN);
  assign last       = ({1'b0, idx_q} == len_q - (AW+1)'(1));
  assign arg_len    = {1'b0, arg} + 5'd1;
  assign unused_uio = ^uio_in[7:4];

  tt_patseq_mem #(.DEPTH(DEPTH)) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(wr_q),
    .wdata({arg, uio_in[3:0]}),
    .raddr(idx_d),
    .rdata(rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else if (ena) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    len_d   = len_q;
    div_d   = div_q;
    tick_d  = tick_q;
    loop_d  = loop_q;
    err_d   = err_q;
    we      = 1'b0;
    if (run) begin
      if (tick_q == div_q) begin
        tick_d = '0;
        if (!last) idx_d = idx_q + AW'(1);
        else if (loop_q) idx_d = '0;
        else state_d = S_DONE;
      end else begin
        tick_d = tick_q + 4'd1;
      end
    end
    if (fire) begin
      unique case (1'b1)
        op == OP_WRITE: begin
          if (run) err_d = 1'b1;
          else begin
            we   = 1'b1;
            wr_d = wr_q + AW'(1);
          end
        end
        op == OP_SET_LEN: begin
          if (run) err_d = 1'b1;
          else if (arg_len >= 5'(DEPTH)) len_d = LEN_MAX;
          else len_d = arg_len[AW:0];
        end
        op == OP_SET_DIV: begin
          if (run) err_d = 1'b1;
          else div_d = arg;
        end
        op == OP_PLAY_ONCE,
        op == OP_PLAY_LOOP: begin
          state_d = S_RUN;
          idx_d   = '0;
          tick_d  = '0;
          loop_d  = op[0];
        end
        op == OP_STOP: state_d = S_IDLE;
        op == OP_CLR: begin
          if (run) err_d = 1'b1;
          else begin
            wr_d  = '0;
            err_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // DONE keeps whatever byte was last on the pins
  always_comb begin
    uo_d = uo_q;
    case (state_d)
      S_IDLE:  uo_d = IDLE_VALUE;
      S_RUN:   uo_d = rdata;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      strb_q <= 1'b0;
      idx_q  <= '0;
      wr_q   <= '0;
      len_q  <= LEN_MAX;
      div_q  <= '0;
      tick_q <= '0;
      loop_q <= 1'b0;
      err_q  <= 1'b0;
      uo_q   <= IDLE_VALUE;
    end else begin
      strb_q <= ui_in[STB_BIT];
      if (ena) begin
        idx_q  <= idx_d;
        wr_q   <= wr_d;
        len_q  <= len_d;
        div_q  <= div_d;
        tick_q <= tick_d;
        loop_q <= loop_d;
        err_q  <= err_d;
        uo_q   <= uo_d;
      end
    end
  end

  assign uo_out = uo_q;

`ifdef TT_PATSEQ_STATUS_EN
  logic [7:0] uio_q, uio_d;

  always_comb begin
    uio_d          = '0;
    uio_d[ST_BUSY] = (state_d == S_RUN);
    uio_d[ST_LOOP] = loop_d;
    uio_d[ST_DONE] = (state_d == S_DONE);
    uio_d[ST_ERR]  = err_d;
  end

  always_ff @(posedge clk) begin
    if (rst) uio_q <= '0;
    else if (ena) uio_q <= uio_d;
  end

  assign uio_out = uio_q;
  assign uio_oe  = 8'hF0;
`else
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;
`endif

endmodule
